// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program counter: FSM states, next-PC
// select codes and the instruction alignment mask.
package pc_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

    typedef enum logic [2:0] {
        SEL_HOLD  = 3'd0,
        SEL_TRAP  = 3'd1,
        SEL_RET   = 3'd2,
        SEL_REDIR = 3'd3,
        SEL_FAULT = 3'd4,
        SEL_SEQ   = 3'd5
    } pc_sel_e;

    // Low address bits that must be zero for a legal target (2- or 4-byte parcels).
    function automatic logic [1:0] align_mask(input int unsigned instr_bytes);
        return (instr_bytes == 2) ? 2'b01 : 2'b11;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux: trap > return > redirect > sequential,
// with misaligned redirects diverted to the trap vector.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(32'h0000_0100),
    parameter int              INSTR_BYTES = 4
) (
    input  logic            active,
    input  logic            trap_valid,
    input  logic            ret_valid,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic [XLEN-1:0] ret_target,
    input  logic            advance,
    input  logic [XLEN-1:0] seq_pc,
    output logic [XLEN-1:0] next_pc,
    output logic            take,
    output logic            fault
);

    localparam logic [1:0] MASK = align_mask(INSTR_BYTES);

    pc_sel_e sel;
    logic    misaligned;

    assign misaligned = |(redirect_target[1:0] & MASK);

    always_comb begin
        sel = SEL_HOLD;
        if (active) begin
            if (trap_valid)
                sel = SEL_TRAP;
            else if (ret_valid)
                sel = SEL_RET;
            else if (redirect_valid)
                sel = misaligned ? SEL_FAULT : SEL_REDIR;
            else if (advance)
                sel = SEL_SEQ;
        end
    end

    always_comb begin
        next_pc = seq_pc;
        case (sel)
            SEL_TRAP,
            SEL_FAULT: next_pc = TRAP_VECTOR;
            SEL_RET:   next_pc = ret_target;
            SEL_REDIR: next_pc = redirect_target;
            default:   next_pc = seq_pc;
        endcase
    end

    assign take  = (sel != SEL_HOLD);
    assign fault = (sel == SEL_FAULT);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: BOOT/RUN/HALT control, valid/ready request to
// instruction memory and registered PC update from pc_next_sel.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int              INSTR_BYTES  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            halt_req,
    input  logic            resume,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic            ret_valid,
    input  logic [XLEN-1:0] ret_target,
    input  logic            fetch_ready,
    output logic            fetch_valid,
    output logic [XLEN-1:0] fetch_addr,
    output logic [XLEN-1:0] pc_next_seq,
    output logic            misalign_fault,
    output logic            halted
);

    localparam logic [XLEN-1:0] INC = XLEN'(INSTR_BYTES);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] next_pc;
    logic            fault_q;
    logic            take, fault;
    logic            active, accept;

    assign active      = (state_q == ST_RUN) || (state_q == ST_HALT);
    assign accept      = fetch_valid & fetch_ready;
    assign pc_next_seq = pc_q + INC;

    pc_next_sel #(
        .XLEN        (XLEN),
        .TRAP_VECTOR (TRAP_VECTOR),
        .INSTR_BYTES (INSTR_BYTES)
    ) u_sel (
        .active          (active),
        .trap_valid      (trap_valid),
        .ret_valid       (ret_valid),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .ret_target      (ret_target),
        .advance         (accept & ~stall),
        .seq_pc          (pc_next_seq),
        .next_pc         (next_pc),
        .take            (take),
        .fault           (fault)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_BOOT;
        else
            state_q <= state_d;
    end

    // Halt waits for the in-flight request to be accepted unless the pipe is stalled.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  if (halt_req && (accept || stall)) state_d = ST_HALT;
            ST_HALT: if (trap_valid || resume) state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase
    end

    always_comb begin
        fetch_valid = (state_q == ST_RUN);
        halted      = (state_q == ST_HALT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_VECTOR;
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault;
            if (state_q == ST_BOOT)
                pc_q <= RESET_VECTOR;
            else if (take)
                pc_q <= next_pc;
        end
    end

    assign fetch_addr     = pc_q;
    assign misalign_fault = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed stimulus pushes expected outputs,
// a negedge monitor pops and compares them (4-byte and 2-byte instances).
module tb_pc_sequencer;

    typedef struct {
        string       nm;
        logic        fv;
        logic [31:0] addr;
        logic [31:0] seq;
        logic        mf;
        logic        hl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, stall, halt_req, resume, redirect_valid, trap_valid, ret_valid, fetch_ready;
    logic [31:0] redirect_target, ret_target;
    logic        fetch_valid, misalign_fault, halted;
    logic [31:0] fetch_addr, pc_next_seq;

    logic        rst2, redirect_valid2, fetch_ready2;
    logic [31:0] redirect_target2;
    logic        fetch_valid2, misalign_fault2, halted2;
    logic [31:0] fetch_addr2, pc_next_seq2;

    exp_t q1[$];
    exp_t q2[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk (clk), .rst (rst), .stall (stall), .halt_req (halt_req), .resume (resume),
        .redirect_valid (redirect_valid), .redirect_target (redirect_target),
        .trap_valid (trap_valid), .ret_valid (ret_valid), .ret_target (ret_target),
        .fetch_ready (fetch_ready), .fetch_valid (fetch_valid), .fetch_addr (fetch_addr),
        .pc_next_seq (pc_next_seq), .misalign_fault (misalign_fault), .halted (halted)
    );

    pc_sequencer #(.INSTR_BYTES(2)) dut2 (
        .clk (clk), .rst (rst2), .stall (1'b0), .halt_req (1'b0), .resume (1'b0),
        .redirect_valid (redirect_valid2), .redirect_target (redirect_target2),
        .trap_valid (1'b0), .ret_valid (1'b0), .ret_target (32'h0),
        .fetch_ready (fetch_ready2), .fetch_valid (fetch_valid2), .fetch_addr (fetch_addr2),
        .pc_next_seq (pc_next_seq2), .misalign_fault (misalign_fault2), .halted (halted2)
    );

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Monitor: one observation per cycle, popped in issue order.
    always @(negedge clk) begin
        exp_t e;
        if (q1.size() > 0) begin
            e = q1.pop_front();
            cmp({e.nm, ".fetch_valid"}, 32'(fetch_valid), 32'(e.fv));
            cmp({e.nm, ".fetch_addr"}, fetch_addr, e.addr);
            cmp({e.nm, ".pc_next_seq"}, pc_next_seq, e.seq);
            cmp({e.nm, ".misalign_fault"}, 32'(misalign_fault), 32'(e.mf));
            cmp({e.nm, ".halted"}, 32'(halted), 32'(e.hl));
        end
        if (q2.size() > 0) begin
            e = q2.pop_front();
            cmp({e.nm, ".fetch_valid"}, 32'(fetch_valid2), 32'(e.fv));
            cmp({e.nm, ".fetch_addr"}, fetch_addr2, e.addr);
            cmp({e.nm, ".pc_next_seq"}, pc_next_seq2, e.seq);
            cmp({e.nm, ".misalign_fault"}, 32'(misalign_fault2), 32'(e.mf));
            cmp({e.nm, ".halted"}, 32'(halted2), 32'(e.hl));
        end
    end

    task automatic step(input string nm, input logic fv, input logic [31:0] a,
                        input logic mf, input logic hl);
        exp_t e;
        e.nm = nm; e.fv = fv; e.addr = a; e.seq = a + 32'd4; e.mf = mf; e.hl = hl;
        q1.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic step2(input string nm, input logic fv, input logic [31:0] a, input logic mf);
        exp_t e;
        e.nm = nm; e.fv = fv; e.addr = a; e.seq = a + 32'd2; e.mf = mf; e.hl = 1'b0;
        q2.push_back(e);
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; halt_req = 1'b0; resume = 1'b0;
        redirect_valid = 1'b0; redirect_target = 32'h0; trap_valid = 1'b0;
        ret_valid = 1'b0; ret_target = 32'h0; fetch_ready = 1'b0;
        rst2 = 1'b1; redirect_valid2 = 1'b0; redirect_target2 = 32'h0; fetch_ready2 = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        step("reset", 0, 32'h0, 0, 0);

        rst = 1'b0; fetch_ready = 1'b1;
        step("boot_exit", 1, 32'h0, 0, 0);
        step("seq4", 1, 32'h4, 0, 0);
        step("seq8", 1, 32'h8, 0, 0);
        step("seqC", 1, 32'hC, 0, 0);
        step("seq10", 1, 32'h10, 0, 0);

        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("notready_hold", 1, 32'h10, 0, 0);
        fetch_ready = 1'b1;
        step("ready_adv", 1, 32'h14, 0, 0);
        step("seq18", 1, 32'h18, 0, 0);
        step("seq1C", 1, 32'h1C, 0, 0);
        step("seq20", 1, 32'h20, 0, 0);

        stall = 1'b1;
        step("stall_hold", 1, 32'h20, 0, 0);
        redirect_valid = 1'b1; redirect_target = 32'h80;
        step("redir_in_stall", 1, 32'h80, 0, 0);

        stall = 1'b0; trap_valid = 1'b1; ret_valid = 1'b1; ret_target = 32'h40;
        step("prio_trap", 1, 32'h100, 0, 0);
        trap_valid = 1'b0; redirect_valid = 1'b0;
        step("ret_only", 1, 32'h40, 0, 0);

        ret_valid = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h82;
        step("misalign", 1, 32'h100, 1, 0);
        redirect_valid = 1'b0; fetch_ready = 1'b0;
        step("misalign_pulse_end", 1, 32'h100, 0, 0);

        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        step("to_top", 1, 32'hFFFF_FFFC, 0, 0);
        redirect_valid = 1'b0; fetch_ready = 1'b1;
        step("wrap", 1, 32'h0, 0, 0);

        halt_req = 1'b1;
        step("halt_on_accept", 0, 32'h4, 0, 1);
        halt_req = 1'b0;
        step("halt_stays", 0, 32'h4, 0, 1);
        resume = 1'b1;
        step("resume", 1, 32'h4, 0, 0);
        resume = 1'b0; fetch_ready = 1'b0; stall = 1'b1; halt_req = 1'b1;
        step("halt_on_stall", 0, 32'h4, 0, 1);
        stall = 1'b0; halt_req = 1'b0; trap_valid = 1'b1; resume = 1'b1;
        step("trap_in_halt", 1, 32'h100, 0, 0);
        trap_valid = 1'b0; resume = 1'b0; halt_req = 1'b1; fetch_ready = 1'b1;
        step("halt_again", 0, 32'h104, 0, 1);
        halt_req = 1'b0; rst = 1'b1;
        step("reset_in_halt", 0, 32'h0, 0, 0);

        rst2 = 1'b0; fetch_ready2 = 1'b1;
        step2("ib2_boot", 1, 32'h0, 0);
        redirect_valid2 = 1'b1; redirect_target2 = 32'h82;
        step2("ib2_redir82", 1, 32'h82, 0);
        redirect_target2 = 32'h83;
        step2("ib2_misalign83", 1, 32'h100, 1);
        redirect_valid2 = 1'b0;
        step2("ib2_seq", 1, 32'h102, 0);

        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (q1.size() != 0 || q2.size() != 0) begin
            errors++;
            $display("FAIL drain: pending %0d/%0d expected 0/0", q1.size(), q2.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
